// File: rtl/selfadd_reg_lanes.sv
// selfadd_reg_lanes: multi-lane self-accumulating register bank with pipelined add
// Ports:
//   clk, rst         clock and asynchronous active-high reset
//   usr_rst          synchronous clear, also cancels the in-flight add and a same-cycle beat
//   data_v, in_data  input beat; lane i is in_data[i*DW +: DW], signed
//   in_ready         a beat is accepted on data_v && in_ready
//   out_data_w       registered accumulators, same lane packing
//   out_data_v_w     one-cycle pulse when the accumulators update
//   ovf_w            per-lane sticky overflow / saturation flag
//   drop_w           sticky flag, data_v seen while in_ready was low
module selfadd_reg_lanes #(
    parameter int LANES    = 2,
    parameter int DW       = 16,
    parameter int ADD_LAT  = 3,
    parameter int SAT_MODE = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                usr_rst,
    input  logic                data_v,
    input  logic [LANES*DW-1:0] in_data,
    output logic                in_ready,
    output logic [LANES*DW-1:0] out_data_w,
    output logic                out_data_v_w,
    output logic [LANES-1:0]    ovf_w,
    output logic                drop_w
);
    logic [ADD_LAT-1:0]    vc;
    logic [LANES*DW-1:0]   op_in  [ADD_LAT];
    logic [LANES*DW-1:0]   op_acc [ADD_LAT];
    logic [LANES*DW-1:0]   acc, nxt, snap;
    logic [LANES-1:0]      of_nxt;
    logic                  wr, accept;

    assign wr = vc[ADD_LAT-1];
    // The top chain bit marks the write edge, so a beat may be accepted on that same edge.
    assign in_ready = ~|(vc & ~(ADD_LAT'(1) << (ADD_LAT - 1)));
    assign accept = data_v & in_ready;
    // Forward the value being written so a beat accepted on the write edge sees it.
    assign snap = wr ? nxt : acc;
    assign out_data_w = acc;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [DW-1:0] a, b;
        logic [DW:0]   s;
        logic          of;
        assign a = op_acc[ADD_LAT-1][i*DW +: DW];
        assign b = op_in[ADD_LAT-1][i*DW +: DW];
        assign s = {a[DW-1], a} + {b[DW-1], b};
        // Sign extension bit disagreeing with the result sign is exactly signed overflow.
        assign of = s[DW] ^ s[DW-1];
        assign of_nxt[i] = of;
        assign nxt[i*DW +: DW] = (SAT_MODE != 0 && of)
            ? (a[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}})
            : s[DW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vc <= '0;
            acc <= '0;
            ovf_w <= '0;
            drop_w <= 1'b0;
            out_data_v_w <= 1'b0;
            for (int k = 0; k < ADD_LAT; k++) begin
                op_in[k] <= '0;
                op_acc[k] <= '0;
            end
        end else if (usr_rst) begin
            vc <= '0;
            acc <= '0;
            ovf_w <= '0;
            drop_w <= 1'b0;
            out_data_v_w <= 1'b0;
            for (int k = 0; k < ADD_LAT; k++) begin
                op_in[k] <= '0;
                op_acc[k] <= '0;
            end
        end else begin
            vc <= (vc << 1) | ADD_LAT'(accept);
            op_in[0] <= in_data;
            op_acc[0] <= snap;
            for (int k = 1; k < ADD_LAT; k++) begin
                op_in[k] <= op_in[k-1];
                op_acc[k] <= op_acc[k-1];
            end
            out_data_v_w <= wr;
            drop_w <= drop_w | (data_v & ~in_ready);
            if (wr) begin
                acc <= nxt;
                ovf_w <= ovf_w | of_nxt;
            end
        end
    end
endmodule

// File: tb/tb_selfadd_reg_lanes.sv
// tb_selfadd_reg_lanes: directed bench for wrap, saturate and single-cycle accumulator banks
module tb_selfadd_reg_lanes;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        urst = 1'b0;
    logic        dv = 1'b0;
    logic [31:0] din = '0;
    logic        rdy0, v0, dr0, rdy1, v1, dr1, rdy2, v2, dr2;
    logic [31:0] d0, d1, d2;
    logic [1:0]  o0, o1, o2;
    int          vecs = 0;
    int          errs = 0;

    always #5 clk = ~clk;

    selfadd_reg_lanes u0 (.clk(clk), .rst(rst), .usr_rst(urst), .data_v(dv), .in_data(din),
        .in_ready(rdy0), .out_data_w(d0), .out_data_v_w(v0), .ovf_w(o0), .drop_w(dr0));
    selfadd_reg_lanes #(.SAT_MODE(1)) u1 (.clk(clk), .rst(rst), .usr_rst(urst), .data_v(dv),
        .in_data(din), .in_ready(rdy1), .out_data_w(d1), .out_data_v_w(v1), .ovf_w(o1),
        .drop_w(dr1));
    selfadd_reg_lanes #(.ADD_LAT(1)) u2 (.clk(clk), .rst(rst), .usr_rst(urst), .data_v(dv),
        .in_data(din), .in_ready(rdy2), .out_data_w(d2), .out_data_v_w(v2), .ovf_w(o2),
        .drop_w(dr2));

    typedef struct {
        bit          clr;
        logic [15:0] a0, a1, w0, w1;
        logic [1:0]  wo;
        logic [15:0] s0, s1;
        logic [1:0]  so;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic clear();
        urst = 1'b1;
        @(negedge clk);
        urst = 1'b0;
        chk("clr_data", d0, 0);
        chk("clr_ovf", o0, 0);
        chk("clr_ready", rdy0, 1);
    endtask

    task automatic beat(input logic [15:0] a0, input logic [15:0] a1);
        int n;
        n = 0;
        while (!rdy0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", n < 20, 1);
        din = {a1, a0};
        dv = 1'b1;
        @(negedge clk);
        dv = 1'b0;
        chk("ready_low", rdy0, 0);
        n = 0;
        while (!v0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, 3);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int p, e;
        tbl[0]  = '{1, 16'h0001, 16'h0002, 16'h0001, 16'h0002, 2'b00, 16'h0001, 16'h0002, 2'b00};
        tbl[1]  = '{0, 16'h0001, 16'h0002, 16'h0002, 16'h0004, 2'b00, 16'h0002, 16'h0004, 2'b00};
        tbl[2]  = '{0, 16'h0001, 16'h0002, 16'h0003, 16'h0006, 2'b00, 16'h0003, 16'h0006, 2'b00};
        tbl[3]  = '{1, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 2'b00, 16'h7FFF, 16'h0000, 2'b00};
        tbl[4]  = '{0, 16'h0001, 16'h0000, 16'h8000, 16'h0000, 2'b01, 16'h7FFF, 16'h0000, 2'b01};
        tbl[5]  = '{1, 16'h7FF0, 16'h8005, 16'h7FF0, 16'h8005, 2'b00, 16'h7FF0, 16'h8005, 2'b00};
        tbl[6]  = '{0, 16'h0100, 16'hFFF0, 16'h80F0, 16'h7FF5, 2'b11, 16'h7FFF, 16'h8000, 2'b11};
        tbl[7]  = '{0, 16'h0010, 16'h0001, 16'h8100, 16'h7FF6, 2'b11, 16'h7FFF, 16'h8001, 2'b11};
        tbl[8]  = '{1, 16'hFFFF, 16'h0003, 16'hFFFF, 16'h0003, 2'b00, 16'hFFFF, 16'h0003, 2'b00};
        tbl[9]  = '{0, 16'hFFFF, 16'hFFFE, 16'hFFFE, 16'h0001, 2'b00, 16'hFFFE, 16'h0001, 2'b00};
        tbl[10] = '{0, 16'h8000, 16'h8000, 16'h7FFE, 16'h8001, 2'b01, 16'h8000, 16'h8001, 2'b01};

        repeat (2) @(negedge clk);
        chk("rst_data", d0, 0);
        chk("rst_ready", rdy0, 1);
        chk("rst_valid", v0, 0);
        chk("rst_ovf", o0, 0);
        chk("rst_drop", dr0, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            if (tbl[i].clr) clear();
            beat(tbl[i].a0, tbl[i].a1);
            chk("wrap_data", d0, {tbl[i].w1, tbl[i].w0});
            chk("wrap_ovf", o0, tbl[i].wo);
            chk("sat_valid", v1, 1);
            chk("sat_data", d1, {tbl[i].s1, tbl[i].s0});
            chk("sat_ovf", o1, tbl[i].so);
            @(negedge clk);
            chk("pulse_once", v0, 0);
        end

        // usr_rst while an add is in flight, together with a beat that would otherwise drop
        din = {16'd1, 16'd1};
        dv = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("drop_set", dr0, 1);
        urst = 1'b1;
        @(negedge clk);
        urst = 1'b0;
        dv = 1'b0;
        chk("urst_data", d0, 0);
        chk("urst_ovf", o0, 0);
        chk("urst_drop", dr0, 0);
        chk("urst_ready", rdy0, 1);
        p = 0;
        repeat (6) begin
            @(negedge clk);
            p += int'(v0);
        end
        chk("urst_no_pulse", p, 0);
        chk("urst_hold", d0, 0);

        // data_v held for 7 cycles: accepts on cycles 0, 3 and 6 only
        clear();
        din = {16'd1, 16'd1};
        dv = 1'b1;
        p = 0;
        repeat (7) begin
            @(negedge clk);
            p += int'(v0);
        end
        dv = 1'b0;
        repeat (6) begin
            @(negedge clk);
            p += int'(v0);
        end
        chk("hold_pulses", p, 3);
        chk("hold_data", d0, {16'd3, 16'd3});
        chk("hold_drop", dr0, 1);

        // asynchronous rst between edges while an add is in flight
        beat(16'd2, 16'd2);
        chk("pre_rst_data", d0, {16'd5, 16'd5});
        din = {16'd1, 16'd1};
        dv = 1'b1;
        @(negedge clk);
        dv = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_data", d0, 0);
        chk("arst_ready", rdy0, 1);
        chk("arst_drop", dr0, 0);
        chk("arst_valid", v0, 0);
        chk("arst_sat_data", d1, 0);
        chk("arst_fast_data", d2, 0);
        @(negedge clk);
        rst = 1'b0;

        // single-cycle adder accumulates every cycle
        din = {16'd1, 16'd1};
        for (int i = 0; i < 4; i++) begin
            e = (i > 0) ? i - 1 : 0;
            chk("fast_ready", rdy2, 1);
            chk("fast_step", d2, {16'(e), 16'(e)});
            dv = 1'b1;
            @(negedge clk);
        end
        dv = 1'b0;
        @(negedge clk);
        chk("fast_final", d2, {16'd4, 16'd4});
        chk("fast_drop", dr2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
